// File: rtl/vending_ctrl.sv
// ---------------------------------------------------------------------------
// vending_ctrl
// Multi-item cash vending controller. Coins credit a balance. A selection
// latches an item. The item is vended once the balance covers its price.
// Change is paid back greedily (quarters, dimes, nickels) over a
// valid/ready handshake to the coin hopper.
//
// Optional feature macro: CARD_PAY_EN
//   When defined, a card can pay for the selected item. All cash credit is
//   then refunded through the change sequence.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_sel_valid/i_sel_idx item selection strobe and index
//   i_coin_*              one-cycle coin pulses (5/10/25/100 cents)
//   i_cancel              refund request
//   i_cfg_*               price/stock table write port (honoured in IDLE)
//   i_coin_out_ready      hopper accepts the offered change coin
//   i_card_valid/_funds   card presentation and available funds (CARD_PAY_EN)
//   o_balance             current cash credit in cents
//   o_busy                high while dispensing or paying change
//   o_dispense_valid/_idx one-cycle vend pulse and the vended item
//   o_coin_out_valid/o_coin_out  change coin offer (01 N, 10 D, 11 Q)
//   o_coin_reject         inserted coins refused (one-cycle pulse)
//   o_err_sold_out        selected item has no stock (one-cycle pulse)
//   o_err_bad_idx         selected index out of range (one-cycle pulse)
//   o_err_card            card funds insufficient (one-cycle pulse, CARD_PAY_EN)
// ---------------------------------------------------------------------------
module vending_ctrl #(
    parameter int NUM_ITEMS = 8,
    parameter int IDX_W     = 3,
    parameter int BAL_W     = 10,
    parameter int STOCK_W   = 4,
    parameter int MAX_BAL   = 995
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sel_valid,
    input  logic [IDX_W-1:0]   i_sel_idx,
    input  logic               i_coin_nickel,
    input  logic               i_coin_dime,
    input  logic               i_coin_quarter,
    input  logic               i_coin_dollar,
    input  logic               i_cancel,
    input  logic               i_cfg_we,
    input  logic [IDX_W-1:0]   i_cfg_idx,
    input  logic [BAL_W-1:0]   i_cfg_price,
    input  logic [STOCK_W-1:0] i_cfg_stock,
    input  logic               i_coin_out_ready,
`ifdef CARD_PAY_EN
    input  logic               i_card_valid,
    input  logic [BAL_W-1:0]   i_card_funds,
    output logic               o_err_card,
`endif
    output logic [BAL_W-1:0]   o_balance,
    output logic               o_busy,
    output logic               o_dispense_valid,
    output logic [IDX_W-1:0]   o_dispense_idx,
    output logic               o_coin_out_valid,
    output logic [1:0]         o_coin_out,
    output logic               o_coin_reject,
    output logic               o_err_sold_out,
    output logic               o_err_bad_idx
);

    // One extra bit so balance + coin sum can be compared against the ceiling
    // without wrapping.
    localparam int SUM_W = BAL_W + 1;

    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAY,
        S_DISPENSE,
        S_CHANGE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [BAL_W-1:0]   r_balance;
    logic [IDX_W-1:0]   r_idx;
    logic [BAL_W-1:0]   r_price [NUM_ITEMS];
    logic [STOCK_W-1:0] r_stock [NUM_ITEMS];
    logic               r_coinReject;
    logic               r_errSoldOut;
    logic               r_errBadIdx;

    logic [SUM_W-1:0]   w_coinSum;
    logic [SUM_W-1:0]   w_balPlus;
    logic               w_coinAny;
    logic               w_coinAccept;
    logic               w_coinReject;
    logic               w_selInRange;
    logic               w_cfgInRange;
    logic [STOCK_W-1:0] w_selStock;
    logic               w_selOk;
    logic               w_idleCancel;
    logic [BAL_W-1:0]   w_price;
    logic [1:0]         w_coinCode;
    logic [BAL_W-1:0]   w_coinVal;
    logic               w_coinValid;
    logic               w_coinTake;
    logic               w_cardOk;
    logic               w_cardPaid;
    logic [BAL_W-1:0]   w_dispRemain;

    // Coin acceptance: all coins of one cycle are summed and either taken
    // together or refused together. Coins are refused outright while
    // dispensing or paying change.
    assign w_coinSum = (i_coin_nickel  ? SUM_W'(5)   : SUM_W'(0))
                     + (i_coin_dime    ? SUM_W'(10)  : SUM_W'(0))
                     + (i_coin_quarter ? SUM_W'(25)  : SUM_W'(0))
                     + (i_coin_dollar  ? SUM_W'(100) : SUM_W'(0));
    assign w_balPlus    = {1'b0, r_balance} + w_coinSum;
    assign w_coinAny    = i_coin_nickel | i_coin_dime | i_coin_quarter | i_coin_dollar;
    assign w_coinAccept = w_coinAny && (r_state == S_IDLE || r_state == S_PAY)
                          && (w_balPlus <= SUM_W'(MAX_BAL));
    assign w_coinReject = w_coinAny && !w_coinAccept;

    // Index range checks. Out-of-range indices never reach the tables.
    assign w_selInRange = ({1'b0, i_sel_idx} < (IDX_W+1)'(NUM_ITEMS));
    assign w_cfgInRange = ({1'b0, i_cfg_idx} < (IDX_W+1)'(NUM_ITEMS));
    assign w_selStock   = w_selInRange ? r_stock[i_sel_idx] : '0;
    assign w_idleCancel = i_cancel && (r_balance != '0);
    assign w_selOk      = i_sel_valid && w_selInRange && (w_selStock != '0);
    assign w_price      = r_price[r_idx];

    // Greedy change selection. The coin follows the registered balance, which
    // only moves on a completed handshake. This keeps the offer stable while
    // the hopper stalls.
    always_comb begin
        w_coinCode = COIN_NONE;
        w_coinVal  = '0;
        if (r_balance >= BAL_W'(25)) begin
            w_coinCode = COIN_QUARTER;
            w_coinVal  = BAL_W'(25);
        end else if (r_balance >= BAL_W'(10)) begin
            w_coinCode = COIN_DIME;
            w_coinVal  = BAL_W'(10);
        end else if (r_balance >= BAL_W'(5)) begin
            w_coinCode = COIN_NICKEL;
            w_coinVal  = BAL_W'(5);
        end
    end

    assign w_coinValid = (r_state == S_CHANGE) && (r_balance != '0);
    assign w_coinTake  = w_coinValid && i_coin_out_ready;

`ifdef CARD_PAY_EN
    logic r_cardPaid;
    logic r_errCard;
    logic w_cardBad;

    // A card qualifies when its funds cover the latched item's price.
    assign w_cardOk   = i_card_valid && (i_card_funds >= w_price);
    assign w_cardBad  = i_card_valid && !w_cardOk;
    assign w_cardPaid = r_cardPaid;
    assign o_err_card = r_errCard;

    // Remember whether the upcoming vend is card-paid, so the cash balance
    // is left intact and refunded in full. Also flag a card with too little
    // funds. A cancel in the same cycle takes precedence over the card.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cardPaid <= 1'b0;
            r_errCard  <= 1'b0;
        end else begin
            r_errCard <= (r_state == S_PAY) && !i_cancel && w_cardBad;
            if (r_state == S_PAY) begin
                r_cardPaid <= !i_cancel && w_cardOk;
            end
        end
    end
`else
    assign w_cardOk   = 1'b0;
    assign w_cardPaid = 1'b0;
`endif

    // Credit left after the vend. A card-paid vend keeps all cash for refund.
    assign w_dispRemain = w_cardPaid ? r_balance : (r_balance - w_price);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. In PAY a cancel beats a qualifying payment. The card
    // beats cash when both qualify. CHANGE returns to IDLE on the handshake
    // that empties the balance, so no idle cycle is spent in CHANGE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_idleCancel) begin
                    w_nextState = S_CHANGE;
                end else if (w_selOk) begin
                    w_nextState = S_PAY;
                end
            end
            S_PAY: begin
                if (i_cancel) begin
                    w_nextState = S_CHANGE;
                end else if (w_cardOk) begin
                    w_nextState = S_DISPENSE;
                end else if (r_balance >= w_price) begin
                    w_nextState = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                w_nextState = (w_dispRemain != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                if (r_balance == '0) begin
                    w_nextState = S_IDLE;
                end else if (w_coinTake && (r_balance == w_coinVal)) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Datapath: balance, latched item, price/stock table and registered
    // error pulses. Table writes are honoured only in IDLE. A selection in
    // the same cycle reads the pre-write table.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_balance    <= '0;
            r_idx        <= '0;
            r_coinReject <= 1'b0;
            r_errSoldOut <= 1'b0;
            r_errBadIdx  <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                r_price[i] <= '0;
                r_stock[i] <= '0;
            end
        end else begin
            r_coinReject <= w_coinReject;
            r_errBadIdx  <= (r_state == S_IDLE) && !w_idleCancel && i_sel_valid
                            && !w_selInRange;
            r_errSoldOut <= (r_state == S_IDLE) && !w_idleCancel && i_sel_valid
                            && w_selInRange && (w_selStock == '0);

            case (r_state)
                S_IDLE, S_PAY: begin
                    if (w_coinAccept) begin
                        r_balance <= w_balPlus[BAL_W-1:0];
                    end
                end
                S_DISPENSE: begin
                    r_balance <= w_dispRemain;
                end
                S_CHANGE: begin
                    if (w_coinTake) begin
                        r_balance <= r_balance - w_coinVal;
                    end
                end
                default: ;
            endcase

            if (r_state == S_IDLE && w_nextState == S_PAY) begin
                r_idx <= i_sel_idx;
            end

            if (r_state == S_DISPENSE) begin
                r_stock[r_idx] <= r_stock[r_idx] - STOCK_W'(1);
            end

            if (r_state == S_IDLE && i_cfg_we && w_cfgInRange) begin
                r_price[i_cfg_idx] <= i_cfg_price;
                r_stock[i_cfg_idx] <= i_cfg_stock;
            end
        end
    end

    // Output decode. The vend and change outputs are driven from the state
    // and are zero outside their states.
    always_comb begin
        o_busy           = (r_state == S_DISPENSE) || (r_state == S_CHANGE);
        o_dispense_valid = (r_state == S_DISPENSE);
        o_dispense_idx   = (r_state == S_DISPENSE) ? r_idx : '0;
        o_coin_out_valid = w_coinValid;
        o_coin_out       = w_coinValid ? w_coinCode : COIN_NONE;
    end

    assign o_balance      = r_balance;
    assign o_coin_reject  = r_coinReject;
    assign o_err_sold_out = r_errSoldOut;
    assign o_err_bad_idx  = r_errBadIdx;

endmodule

// File: tb/tb_vending_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vending_ctrl
// Directed bench for vending_ctrl with six items. Expected vends and change
// coins are queued as stimulus is driven. A negedge monitor pops and compares
// them when the DUT presents them. Level checks are made #1 after each edge.
// ---------------------------------------------------------------------------
module tb_vending_ctrl;

    localparam int NUM_ITEMS = 6;
    localparam int IDX_W     = 3;
    localparam int BAL_W     = 10;
    localparam int STOCK_W   = 4;
    localparam int MAX_BAL   = 995;

    logic               clk = 1'b0;
    logic               rst;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic               coin_nickel, coin_dime, coin_quarter, coin_dollar;
    logic               cancel;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic [BAL_W-1:0]   cfg_price;
    logic [STOCK_W-1:0] cfg_stock;
    logic               coin_out_ready;
    logic [BAL_W-1:0]   balance;
    logic               busy;
    logic               dispense_valid;
    logic [IDX_W-1:0]   dispense_idx;
    logic               coin_out_valid;
    logic [1:0]         coin_out;
    logic               coin_reject;
    logic               err_sold_out;
    logic               err_bad_idx;
`ifdef CARD_PAY_EN
    logic               card_valid;
    logic [BAL_W-1:0]   card_funds;
    logic               err_card;
`endif

    int checks = 0;
    int errors = 0;

    logic [IDX_W-1:0] expDisp [$];
    logic [1:0]       expCoin [$];
    logic [IDX_W-1:0] monIdx;
    logic [1:0]       monCoin;

    always #5 clk = ~clk;

    vending_ctrl #(
        .NUM_ITEMS (NUM_ITEMS),
        .IDX_W     (IDX_W),
        .BAL_W     (BAL_W),
        .STOCK_W   (STOCK_W),
        .MAX_BAL   (MAX_BAL)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_sel_valid      (sel_valid),
        .i_sel_idx        (sel_idx),
        .i_coin_nickel    (coin_nickel),
        .i_coin_dime      (coin_dime),
        .i_coin_quarter   (coin_quarter),
        .i_coin_dollar    (coin_dollar),
        .i_cancel         (cancel),
        .i_cfg_we         (cfg_we),
        .i_cfg_idx        (cfg_idx),
        .i_cfg_price      (cfg_price),
        .i_cfg_stock      (cfg_stock),
        .i_coin_out_ready (coin_out_ready),
`ifdef CARD_PAY_EN
        .i_card_valid     (card_valid),
        .i_card_funds     (card_funds),
        .o_err_card       (err_card),
`endif
        .o_balance        (balance),
        .o_busy           (busy),
        .o_dispense_valid (dispense_valid),
        .o_dispense_idx   (dispense_idx),
        .o_coin_out_valid (coin_out_valid),
        .o_coin_out       (coin_out),
        .o_coin_reject    (coin_reject),
        .o_err_sold_out   (err_sold_out),
        .o_err_bad_idx    (err_bad_idx)
    );

    // Scoreboard monitor: every vend and every accepted change coin must
    // match the head of the matching expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (dispense_valid) begin
                checks++;
                assert (expDisp.size() != 0) else begin
                    errors++;
                    $error("[TB] FAIL dispense_unexpected: observed idx %0d, expected no vend", dispense_idx);
                end
                if (expDisp.size() != 0) begin
                    monIdx = expDisp.pop_front();
                    assert (dispense_idx === monIdx) else begin
                        errors++;
                        $error("[TB] FAIL dispense_idx: observed %0d, expected %0d", dispense_idx, monIdx);
                    end
                end
            end
            if (coin_out_valid && coin_out_ready) begin
                checks++;
                assert (expCoin.size() != 0) else begin
                    errors++;
                    $error("[TB] FAIL coin_unexpected: observed coin %0d, expected no coin", coin_out);
                end
                if (expCoin.size() != 0) begin
                    monCoin = expCoin.pop_front();
                    assert (coin_out === monCoin) else begin
                        errors++;
                        $error("[TB] FAIL coin_out: observed %0d, expected %0d", coin_out, monCoin);
                    end
                end
            end
        end
    end

    // Hard stop if the sequence stalls somewhere unforeseen.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of front-panel stimulus. coins = {dollar, quarter, dime, nickel}.
    task automatic applyStimulus(input logic [3:0] coins, input logic sel,
                                 input logic [IDX_W-1:0] idx, input logic canc);
        coin_nickel  = coins[0];
        coin_dime    = coins[1];
        coin_quarter = coins[2];
        coin_dollar  = coins[3];
        sel_valid    = sel;
        sel_idx      = idx;
        cancel       = canc;
        tick();
        coin_nickel  = 1'b0;
        coin_dime    = 1'b0;
        coin_quarter = 1'b0;
        coin_dollar  = 1'b0;
        sel_valid    = 1'b0;
        cancel       = 1'b0;
    endtask

    task automatic writeCfg(input logic [IDX_W-1:0] idx, input int price, input int stock);
        cfg_we    = 1'b1;
        cfg_idx   = idx;
        cfg_price = BAL_W'(price);
        cfg_stock = STOCK_W'(stock);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic drainChange(input int maxCycles);
        for (int i = 0; i < maxCycles && busy; i++) begin
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        sel_valid = 1'b0; sel_idx = '0; cancel = 1'b0;
        coin_nickel = 1'b0; coin_dime = 1'b0; coin_quarter = 1'b0; coin_dollar = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_price = '0; cfg_stock = '0;
        coin_out_ready = 1'b0;
`ifdef CARD_PAY_EN
        card_valid = 1'b0; card_funds = '0;
`endif
        tick();
        tick();
        checkOutput("reset_balance", 32'(balance), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_dispense_valid", 32'(dispense_valid), 0);
        checkOutput("reset_coin_out_valid", 32'(coin_out_valid), 0);
        rst = 1'b0;

        $display("[TB] table load");
        writeCfg(2, 65, 1);
        writeCfg(1, 30, 5);
        writeCfg(3, 0, 1);

        $display("[TB] buy item 2 with three quarters");
        applyStimulus(4'b0000, 1'b1, 3'd2, 1'b0);
        checkOutput("pay_busy", 32'(busy), 0);
        applyStimulus(4'b0100, 1'b0, 3'd0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 3'd0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 3'd0, 1'b0);
        checkOutput("three_quarters_balance", 32'(balance), 75);
        expDisp.push_back(3'd2);
        expCoin.push_back(2'b10);
        coin_out_ready = 1'b1;
        tick();
        checkOutput("vend2_valid", 32'(dispense_valid), 1);
        checkOutput("vend2_idx", 32'(dispense_idx), 2);
        tick();
        checkOutput("vend2_change_balance", 32'(balance), 10);
        checkOutput("vend2_coin_valid", 32'(coin_out_valid), 1);
        checkOutput("vend2_coin", 32'(coin_out), 2);
        tick();
        checkOutput("vend2_done_balance", 32'(balance), 0);
        checkOutput("vend2_done_busy", 32'(busy), 0);
        applyStimulus(4'b0000, 1'b1, 3'd2, 1'b0);
        checkOutput("sold_out_pulse", 32'(err_sold_out), 1);
        checkOutput("sold_out_busy", 32'(busy), 0);
        tick();
        checkOutput("sold_out_one_cycle", 32'(err_sold_out), 0);

        $display("[TB] multi-coin cycle then cancel with stalled hopper");
        applyStimulus(4'b0111, 1'b0, 3'd0, 1'b0);
        checkOutput("multi_coin_balance", 32'(balance), 40);
        coin_out_ready = 1'b0;
        applyStimulus(4'b0000, 1'b0, 3'd0, 1'b1);
        checkOutput("cancel_busy", 32'(busy), 1);
        checkOutput("cancel_coin", 32'(coin_out), 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_coin", 32'(coin_out), 3);
            checkOutput("stall_balance", 32'(balance), 40);
        end
        expCoin.push_back(2'b11);
        expCoin.push_back(2'b10);
        expCoin.push_back(2'b01);
        coin_out_ready = 1'b1;
        tick();
        checkOutput("refund_after_q", 32'(balance), 15);
        tick();
        checkOutput("refund_after_d", 32'(balance), 5);
        tick();
        checkOutput("refund_done_balance", 32'(balance), 0);
        checkOutput("refund_done_busy", 32'(busy), 0);

        $display("[TB] balance ceiling");
        for (int i = 0; i < 9; i++) applyStimulus(4'b1000, 1'b0, 3'd0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 3'd0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 3'd0, 1'b0);
        checkOutput("ceiling_balance_950", 32'(balance), 950);
        applyStimulus(4'b1000, 1'b0, 3'd0, 1'b0);
        checkOutput("dollar_reject", 32'(coin_reject), 1);
        checkOutput("dollar_reject_balance", 32'(balance), 950);
        applyStimulus(4'b0111, 1'b0, 3'd0, 1'b0);
        checkOutput("mix_accept_reject", 32'(coin_reject), 0);
        applyStimulus(4'b0001, 1'b0, 3'd0, 1'b0);
        checkOutput("exact_ceiling_balance", 32'(balance), 995);
        applyStimulus(4'b0001, 1'b0, 3'd0, 1'b0);
        checkOutput("over_ceiling_reject", 32'(coin_reject), 1);
        checkOutput("over_ceiling_balance", 32'(balance), 995);
        coin_out_ready = 1'b0;
        applyStimulus(4'b0000, 1'b0, 3'd0, 1'b1);
        applyStimulus(4'b0001, 1'b0, 3'd0, 1'b0);
        checkOutput("change_coin_reject", 32'(coin_reject), 1);
        checkOutput("change_coin_balance", 32'(balance), 995);
        for (int i = 0; i < 39; i++) expCoin.push_back(2'b11);
        expCoin.push_back(2'b10);
        expCoin.push_back(2'b10);
        coin_out_ready = 1'b1;
        drainChange(80);
        checkOutput("big_refund_busy", 32'(busy), 0);
        checkOutput("big_refund_balance", 32'(balance), 0);

        $display("[TB] bad index, locked table, zero price");
        applyStimulus(4'b0000, 1'b1, 3'd7, 1'b0);
        checkOutput("bad_idx_7", 32'(err_bad_idx), 1);
        checkOutput("bad_idx_busy", 32'(busy), 0);
        applyStimulus(4'b0000, 1'b1, 3'd6, 1'b0);
        checkOutput("bad_idx_6", 32'(err_bad_idx), 1);
        applyStimulus(4'b0000, 1'b1, 3'd5, 1'b0);
        checkOutput("empty_idx_5_sold_out", 32'(err_sold_out), 1);
        checkOutput("empty_idx_5_bad_idx", 32'(err_bad_idx), 0);
        applyStimulus(4'b0000, 1'b1, 3'd1, 1'b0);
        writeCfg(1, 5, 9);
        applyStimulus(4'b0100, 1'b0, 3'd0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 3'd0, 1'b0);
        checkOutput("locked_table_no_vend", 32'(dispense_valid), 0);
        checkOutput("locked_table_balance", 32'(balance), 25);
        expDisp.push_back(3'd1);
        applyStimulus(4'b0001, 1'b0, 3'd0, 1'b0);
        tick();
        checkOutput("vend1_valid", 32'(dispense_valid), 1);
        tick();
        checkOutput("vend1_done_busy", 32'(busy), 0);
        checkOutput("vend1_done_balance", 32'(balance), 0);
        expDisp.push_back(3'd3);
        applyStimulus(4'b0000, 1'b1, 3'd3, 1'b0);
        tick();
        checkOutput("free_vend_valid", 32'(dispense_valid), 1);
        tick();
        checkOutput("free_vend_busy", 32'(busy), 0);
        applyStimulus(4'b0000, 1'b1, 3'd3, 1'b0);
        checkOutput("free_item_sold_out", 32'(err_sold_out), 1);

        $display("[TB] reset during change");
        applyStimulus(4'b0110, 1'b0, 3'd0, 1'b0);
        coin_out_ready = 1'b0;
        applyStimulus(4'b0000, 1'b0, 3'd0, 1'b1);
        checkOutput("pre_reset_busy", 32'(busy), 1);
        checkOutput("pre_reset_balance", 32'(balance), 35);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("post_reset_balance", 32'(balance), 0);
        checkOutput("post_reset_coin_valid", 32'(coin_out_valid), 0);
        checkOutput("post_reset_busy", 32'(busy), 0);
        applyStimulus(4'b0000, 1'b1, 3'd1, 1'b0);
        checkOutput("post_reset_table_cleared", 32'(err_sold_out), 1);
        coin_out_ready = 1'b1;

`ifdef CARD_PAY_EN
        $display("[TB] card payment");
        writeCfg(0, 150, 3);
        applyStimulus(4'b0010, 1'b0, 3'd0, 1'b0);
        applyStimulus(4'b0010, 1'b0, 3'd0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 3'd0, 1'b0);
        card_valid = 1'b1;
        card_funds = BAL_W'(100);
        tick();
        card_valid = 1'b0;
        checkOutput("card_short_err", 32'(err_card), 1);
        checkOutput("card_short_busy", 32'(busy), 0);
        expDisp.push_back(3'd0);
        expCoin.push_back(2'b10);
        expCoin.push_back(2'b10);
        card_valid = 1'b1;
        card_funds = BAL_W'(200);
        tick();
        card_valid = 1'b0;
        checkOutput("card_vend_valid", 32'(dispense_valid), 1);
        tick();
        checkOutput("card_cash_kept", 32'(balance), 20);
        tick();
        checkOutput("card_refund_mid", 32'(balance), 10);
        tick();
        checkOutput("card_refund_done", 32'(balance), 0);
        checkOutput("card_refund_busy", 32'(busy), 0);
`endif

        tick();
        checkOutput("disp_queue_empty", 32'(expDisp.size()), 0);
        checkOutput("coin_queue_empty", 32'(expCoin.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_ctrl.md
Name: vending_ctrl

Overview:
Parametrised multi-item vending controller.
- Accepts coin pulses for cash payment and holds a per-item price and stock table loaded through a config port.
- Vends one item per transaction and returns change automatically as a coin stream (quarters, dimes, nickels) over a valid/ready handshake.
- Sits between the front-panel or coin-acceptor inputs and the dispenser and coin-hopper actuators.

Parameters:
NUM_ITEMS, 8, number of selectable items (indices 0..NUM_ITEMS-1)
IDX_W, 3, item index width; must satisfy 2**IDX_W >= NUM_ITEMS
BAL_W, 10, width of prices and balance, in cents
STOCK_W, 4, per-item stock counter width
MAX_BAL, 995, balance ceiling in cents; must be a multiple of 5 and below 2**BAL_W

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
sel_valid  in  1  item selection strobe
sel_idx  in  IDX_W  selected item
coin_nickel, coin_dime, coin_quarter, coin_dollar  in  1 each  one-cycle coin pulses (5/10/25/100 cents)
cancel  in  1  refund request
cfg_we  in  1  price/stock table write strobe
cfg_idx  in  IDX_W  table entry
cfg_price  in  BAL_W  price written
cfg_stock  in  STOCK_W  stock written
balance  out  BAL_W  current cash credit
busy  out  1  high in DISPENSE and CHANGE
dispense_valid  out  1  one-cycle vend pulse
dispense_idx  out  IDX_W  item vended, valid with dispense_valid
coin_out_valid  out  1  change coin offered
coin_out  out  2  01 nickel, 10 dime, 11 quarter
coin_out_ready  in  1  hopper accepts the offered coin
coin_reject  out  1  one-cycle pulse: inserted coins refused
err_sold_out  out  1  one-cycle pulse
err_bad_idx  out  1  one-cycle pulse

Behaviour:
- Reset: state IDLE. balance, prices, stock and all outputs are 0. A reset mid-transaction discards any held credit.
- States: IDLE, PAY, DISPENSE, CHANGE.
- Coins, accepted in IDLE and PAY only:
  - Coins asserted in the same cycle are summed.
  - The sum is added to balance at the clock edge and is visible the next cycle.
  - If balance+sum > MAX_BAL, or the state is DISPENSE or CHANGE, all coins that cycle are refused: coin_reject pulses and balance is unchanged.
- IDLE:
  - On sel_valid: sel_idx >= NUM_ITEMS gives an err_bad_idx pulse. Stock 0 gives an err_sold_out pulse. Otherwise the index is latched and the next state is PAY.
  - cancel with balance != 0 goes to CHANGE. cancel wins over sel_valid in the same cycle.
- PAY:
  - Each cycle, registered balance >= price[idx] goes to DISPENSE.
  - cancel goes to CHANGE. Coins arriving in the cancel cycle are accepted and included in the refund.
  - A price of 0 vends on the first PAY cycle.
- DISPENSE, exactly one cycle:
  - dispense_valid=1 with dispense_idx.
  - stock[idx] decrements by 1.
  - balance decreases by price[idx].
  - Next state is CHANGE if the remaining balance != 0, else IDLE.
  - cancel is ignored.
- CHANGE:
  - Greedy selection: coin_out is the largest of 25/10/5 that is <= balance. coin_out_valid is held until coin_out_ready.
  - On valid&&ready, balance decreases by the coin value at that edge.
  - When balance reaches 0, next state is IDLE. coin_out_valid is never asserted with balance 0.
  - Dollars are never returned. cancel and sel_valid are ignored.
- coin_out is stable while coin_out_valid && !coin_out_ready.
- Config writes:
  - cfg_we is honoured in IDLE only and silently ignored in other states.
  - cfg_idx >= NUM_ITEMS is ignored.
  - If cfg_we and sel_valid occur in the same cycle, the selection is evaluated against the pre-write table.
- Balance is always a multiple of 5, so change always terminates.

Optional Feature:
CARD_PAY_EN
- Defined: adds inputs card_valid (1) and card_funds (BAL_W), and output err_card (1 pulse).
  - In PAY, card_valid with card_funds >= price[idx] goes to DISPENSE. The price is charged to the card and cash balance is not decremented; the full cash balance is then refunded via CHANGE.
  - In PAY, card_valid with card_funds < price[idx] pulses err_card and stays in PAY.
  - If card and cash both qualify in the same cycle, the card has priority.
- Undefined: these ports are absent and the controller is cash only.

Test Plan:
- Price[2]=65, stock[2]=1; select 2; three quarters on separate cycles -> dispense_valid with idx 2, balance 10, one dime out, IDLE; select 2 again -> err_sold_out.
- Dime, quarter and nickel in one cycle then cancel -> balance 40; coins quarter, dime, nickel in order; hold coin_out_ready low 3 cycles -> coin_out stable, balance unchanged until ready.
- Balance 950 then dollar -> coin_reject, balance stays 950; a nickel during CHANGE -> coin_reject.
- sel_idx=7 with NUM_ITEMS=6 -> err_bad_idx, stays IDLE; cfg_we during PAY -> table unchanged.
- rst asserted in CHANGE with balance 35 -> next cycle IDLE, balance 0, coin_out_valid 0.
- CARD_PAY_EN: price 150, cash 20, card_funds 100 -> err_card; card_funds 200 -> dispense, then quarter refusal not needed, 20 refunded as dime, dime.
